cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
// Writeback stage downstream of the issuer's functional units. Buffers each FU's
// completed result in a small per-FU queue, round-robin arbitrates the queues
// onto the single common data bus (cdbval/cdbid/cdbtransmit), and returns
// per-FU back-pressure that drives the issuer's fus_busy input.
// PARAMETERS
// FU_COUNT  8  number of functional units / result queues
// QDEPTH    2  entries per FU result queue (power of 2, >=1)
// PORTS
// clk          in   1                 clock
// rst          in   1                 synchronous reset, active-high
// flush        in   1                 mispredict flush: drop all queued results
// fu_valid     in   FU_COUNT          FU i presents a result this cycle
// fu_result    in   [FU_COUNT][8]     result value per FU
// fu_robid     in   [FU_COUNT][4]     destination ROB/PRF tag per FU
// fu_busy      out  FU_COUNT          queue i full; FU i must not complete/issue
// cdbval       out  8                 broadcast value
// cdbid        out  4                 broadcast tag
// cdbtransmit  out  1                 cdbval/cdbid valid this cycle
// BEHAVIOUR
// - Reset/flush: all queues emptied, rr_ptr=0, cdbtransmit=0, cdbval=0, cdbid=0,
//   fu_busy=0; all take effect on the same edge. Flush and rst win over push/pop
//   in the same cycle.
// - Queue i: circular FIFO, head/tail ptrs wrap mod QDEPTH, count 0..QDEPTH.
//   push = fu_valid[i] & ~fu_busy[i]; fu_valid while busy is dropped (protocol
//   error; the FU must honour fu_busy).
// - fu_busy[i] = (count[i]==QDEPTH), from registered count. No push-through when
//   full even if the same cycle pops.
// - Arbiter (comb): candidates = non-empty queues. Winner = first candidate
//   scanning i = rr_ptr, rr_ptr+1, ... wrapping mod FU_COUNT. Pop the winner's
//   head. rr_ptr <= winner+1 (wrap); unchanged if no candidate.
// - Output regs: if winner exists, cdbtransmit<=1, cdbval/cdbid<=head entry;
//   else cdbtransmit<=0, cdbval/cdbid<=0 (zeros idle so OR-style consumers are safe).
// - Latency: result valid in cycle t -> captured end of t -> cdbtransmit in t+2
//   when uncontended. Exactly one broadcast per cycle max.
// - Fairness: a non-empty queue is granted within FU_COUNT cycles.
// - Simultaneous push+pop on the same queue: count unchanged; the popped entry
//   is the old head; FIFO order is preserved per FU.
// - Across FUs, broadcast order follows arbitration, not completion order.
// CONFIGURATION
// CDB_BYPASS_EN defined: an empty queue whose fu_valid is high is itself a
//   candidate; if it wins, the incoming result goes straight to the output regs
//   without being queued (latency t -> t+1). If it loses, it is pushed normally.
// CDB_BYPASS_EN undefined: bypass logic is absent; latency is always >= 2.
// TESTING
// 1 rst, then fu_valid[3]=1 val=8'hA5 id=4'h7 for 1 cycle -> cdbtransmit=1,
//   cdbval=A5, cdbid=7 exactly at t+2 (t+1 with CDB_BYPASS_EN); idle 0 after.
// 2 FU0,FU1,FU2 each valid for 1 cycle at t=0 with ids 1,2,3, rr_ptr=0 ->
//   ids 1,2,3 broadcast on consecutive cycles; rr_ptr ends at 3.
// 3 FU5 valid for 3 consecutive cycles, QDEPTH=2, CDB held by other FUs ->
//   fu_busy[5]=1 once count=2; third result is dropped; no overflow.
// 4 All 8 FUs hold a result continuously -> grants rotate 0..7,0..; none
//   starved; cdbtransmit=1 every cycle.
// 5 Queues partly full, assert flush 1 cycle -> next cycle cdbtransmit=0, all
//   fu_busy=0; a later push to FU2 broadcasts normally.
// 6 push+pop on full FU4 queue in the same cycle -> push refused (busy), head
//   broadcast; count goes 2->1; order of remaining entries unchanged.

Source files
------------

// File: rtl/cdb_arbiter.sv
// ============================================================================
// cdb_arbiter
// ----------------------------------------------------------------------------
// Writeback stage that sits after the functional units (FUs). Each FU's
// completed result goes into a small circular queue for that FU. The queues
// are round-robin arbitrated onto the single common data bus (CDB), with at
// most one broadcast per cycle. A full queue raises fu_busy so the issuer
// stops issuing to that FU.
//
// Configuration macro:
//   CDB_BYPASS_EN - when defined, an empty queue whose FU presents a result
//                   this cycle is also an arbitration candidate. If it wins,
//                   the result goes straight to the CDB output registers
//                   (latency 1). If it loses, it is queued as usual. When
//                   undefined, every result is queued first (latency >= 2).
//
// Parameters:
//   FU_COUNT - number of functional units / result queues
//   QDEPTH   - entries per FU result queue (power of 2, >= 1)
//
// Ports:
//   clk          in   clock
//   rst          in   synchronous reset, active-high
//   flush        in   mispredict flush; drops every queued result
//   fu_valid     in   [FU_COUNT]      FU i presents a result this cycle
//   fu_result    in   [FU_COUNT][8]   result value per FU
//   fu_robid     in   [FU_COUNT][4]   destination ROB/PRF tag per FU
//   fu_busy      out  [FU_COUNT]      queue i is full; FU i must hold off
//   cdbval       out  [8]             broadcast value (zero when idle)
//   cdbid        out  [4]             broadcast tag   (zero when idle)
//   cdbtransmit  out                  cdbval/cdbid valid this cycle
// ============================================================================
module cdb_arbiter #(
    parameter int FU_COUNT = 8,
    parameter int QDEPTH   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [FU_COUNT-1:0]      fu_valid,
    input  logic [FU_COUNT-1:0][7:0] fu_result,
    input  logic [FU_COUNT-1:0][3:0] fu_robid,
    output logic [FU_COUNT-1:0]      fu_busy,
    output logic [7:0]               cdbval,
    output logic [3:0]               cdbid,
    output logic                     cdbtransmit
);

    // ------------------------------------------------------------------------
    // Widths and constants
    // ------------------------------------------------------------------------
    localparam int PW = (QDEPTH   > 1) ? $clog2(QDEPTH)   : 1;  // queue pointer
    localparam int CW = $clog2(QDEPTH + 1);                     // 0..QDEPTH
    localparam int RW = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;  // rr pointer

    localparam logic [PW-1:0] PTR_LAST = PW'(QDEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(QDEPTH);
    localparam logic [RW-1:0] RR_LAST  = RW'(FU_COUNT - 1);

    typedef struct packed {
        logic [7:0] val;
        logic [3:0] id;
    } entry_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    entry_t        mem_q   [FU_COUNT][QDEPTH];
    logic [PW-1:0] head_q  [FU_COUNT];
    logic [PW-1:0] head_d  [FU_COUNT];
    logic [PW-1:0] tail_q  [FU_COUNT];
    logic [PW-1:0] tail_d  [FU_COUNT];
    logic [CW-1:0] count_q [FU_COUNT];
    logic [CW-1:0] count_d [FU_COUNT];
    logic [RW-1:0] rr_ptr_q, rr_ptr_d;

    logic          cdbtransmit_q, cdbtransmit_d;
    entry_t        cdb_q, cdb_d;

    // ------------------------------------------------------------------------
    // Per-queue status and candidate selection
    // ------------------------------------------------------------------------
    logic [FU_COUNT-1:0] busy_w;
    logic [FU_COUNT-1:0] nonempty_w;
    logic [FU_COUNT-1:0] accept_w;   // result accepted this cycle (queued or bypassed)
    logic [FU_COUNT-1:0] cand_w;

    // NOTE: every signal written in an always_comb gets a default before any
    // conditional logic; otherwise a path that skips the assignment would
    // infer a latch.
    always_comb begin
        busy_w     = '0;
        nonempty_w = '0;
        for (int i = 0; i < FU_COUNT; i++) begin
            // Busy comes from the registered count only: a full queue refuses
            // a push even in a cycle where it is also popped.
            busy_w[i]     = (count_q[i] == CNT_FULL);
            nonempty_w[i] = (count_q[i] != '0);
        end
        // A valid result presented while busy is a protocol error and is dropped.
        accept_w = fu_valid & ~busy_w;
`ifdef CDB_BYPASS_EN
        // An empty queue with an incoming result competes directly.
        cand_w = nonempty_w | (fu_valid & ~nonempty_w);
`else
        cand_w = nonempty_w;
`endif
    end

    assign fu_busy = busy_w;

    // ------------------------------------------------------------------------
    // Round-robin arbiter: first candidate scanning from rr_ptr upward, wrapping
    // ------------------------------------------------------------------------
    logic          win_found;
    logic [RW-1:0] win_idx;

    always_comb begin
        logic [RW-1:0] idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = '0;
        for (int k = 0; k < FU_COUNT; k++) begin
            idx = RW'((int'(rr_ptr_q) + k) % FU_COUNT);
            if (!win_found && cand_w[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    // Winner's entry, and which queue pops / which result skips its queue
    logic [FU_COUNT-1:0] pop_w;
    logic [FU_COUNT-1:0] bypass_w;
    logic [FU_COUNT-1:0] push_w;
    entry_t              win_entry;

    always_comb begin
        pop_w     = '0;
        bypass_w  = '0;
        win_entry = mem_q[win_idx][head_q[win_idx]];
        if (win_found) begin
            if (nonempty_w[win_idx]) begin
                pop_w[win_idx] = 1'b1;
            end
`ifdef CDB_BYPASS_EN
            else begin
                // Winner was empty, so it can only have won through its
                // incoming result: forward it without queueing.
                bypass_w[win_idx] = 1'b1;
                win_entry.val     = fu_result[win_idx];
                win_entry.id      = fu_robid[win_idx];
            end
`endif
        end
        push_w = accept_w & ~bypass_w;
    end

    // ------------------------------------------------------------------------
    // Queue pointer / count next state
    // ------------------------------------------------------------------------
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        for (int i = 0; i < FU_COUNT; i++) begin
            head_d[i]  = head_q[i];
            tail_d[i]  = tail_q[i];
            count_d[i] = count_q[i];
            if (pop_w[i]) begin
                head_d[i] = ptr_inc(head_q[i]);
            end
            if (push_w[i]) begin
                tail_d[i] = ptr_inc(tail_q[i]);
            end
            // Push and pop together leave the count unchanged.
            case ({push_w[i], pop_w[i]})
                2'b10:   count_d[i] = count_q[i] + CW'(1);
                2'b01:   count_d[i] = count_q[i] - CW'(1);
                default: count_d[i] = count_q[i];
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Arbiter pointer and CDB output next state
    // ------------------------------------------------------------------------
    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        cdbtransmit_d = 1'b0;
        cdb_d         = '0;  // idle bus carries zeros for OR-style consumers
        if (win_found) begin
            rr_ptr_d      = (win_idx == RR_LAST) ? '0 : win_idx + RW'(1);
            cdbtransmit_d = 1'b1;
            cdb_d         = win_entry;
        end
    end

    // ------------------------------------------------------------------------
    // Control registers: reset and flush both clear everything on one edge
    // and take priority over any push/pop in the same cycle.
    // ------------------------------------------------------------------------
    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < FU_COUNT; i++) begin
                head_q[i]  <= '0;
                tail_q[i]  <= '0;
                count_q[i] <= '0;
            end
            rr_ptr_q      <= '0;
            cdbtransmit_q <= 1'b0;
            cdb_q         <= '0;
        end else begin
            for (int i = 0; i < FU_COUNT; i++) begin
                head_q[i]  <= head_d[i];
                tail_q[i]  <= tail_d[i];
                count_q[i] <= count_d[i];
            end
            rr_ptr_q      <= rr_ptr_d;
            cdbtransmit_q <= cdbtransmit_d;
            cdb_q         <= cdb_d;
        end
    end

    // ------------------------------------------------------------------------
    // Queue storage
    // ------------------------------------------------------------------------
    // NOTE: the entry storage has no reset; an entry is only read when the
    // count says it was written, so clearing the pointers is sufficient and
    // the array can map onto plain flops or RAM without a reset network.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FU_COUNT; i++) begin
            if (push_w[i]) begin
                mem_q[i][tail_q[i]] <= '{val: fu_result[i], id: fu_robid[i]};
            end
        end
    end

    assign cdbtransmit = cdbtransmit_q;
    assign cdbval      = cdb_q.val;
    assign cdbid       = cdb_q.id;

endmodule

// File: tb/tb_cdb_arbiter.sv
// ============================================================================
// tb_cdb_arbiter
// ----------------------------------------------------------------------------
// Directed bench for cdb_arbiter. The stimulus thread pushes each expected
// CDB broadcast (id,value) into a scoreboard queue in the order the
// round-robin arbitration must produce it; a monitor pops and compares
// whenever cdbtransmit is high and checks the bus is zero when idle.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// on the falling edge.
// ============================================================================
module tb_cdb_arbiter;

    localparam int FU_COUNT = 8;
    localparam int QDEPTH   = 2;
`ifdef CDB_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic                     clk;
    logic                     rst;
    logic                     flush;
    logic [FU_COUNT-1:0]      fu_valid;
    logic [FU_COUNT-1:0][7:0] fu_result;
    logic [FU_COUNT-1:0][3:0] fu_robid;
    logic [FU_COUNT-1:0]      fu_busy;
    logic [7:0]               cdbval;
    logic [3:0]               cdbid;
    logic                     cdbtransmit;

    cdb_arbiter #(.FU_COUNT(FU_COUNT), .QDEPTH(QDEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .fu_valid    (fu_valid),
        .fu_result   (fu_result),
        .fu_robid    (fu_robid),
        .fu_busy     (fu_busy),
        .cdbval      (cdbval),
        .cdbid       (cdbid),
        .cdbtransmit (cdbtransmit)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests_run = 0;
    int tests_failed = 0;

    // Expected broadcasts: {id, val}
    logic [11:0] sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        if (!rst) begin
            if (cdbtransmit) begin
                if (sb.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_broadcast: got id=%h val=%h, expected no broadcast (t=%0t)",
                             cdbid, cdbval, $time);
                end else begin
                    logic [11:0] exp_e;
                    exp_e = sb.pop_front();
                    check("cdb_entry", {20'd0, cdbid, cdbval}, {20'd0, exp_e});
                end
            end else begin
                check("idle_zero", {20'd0, cdbid, cdbval}, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        fu_valid  = '0;
        fu_result = '0;
        fu_robid  = '0;
    endtask

    task automatic drive(input int i, input logic [7:0] v, input logic [3:0] id);
        fu_valid[i]  = 1'b1;
        fu_result[i] = v;
        fu_robid[i]  = id;
    endtask

    task automatic sb_push(input logic [7:0] v, input logic [3:0] id);
        sb.push_back({id, v});
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        flush = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_transmit", {31'd0, cdbtransmit}, 32'd0);
        check("reset_busy", {24'd0, fu_busy}, 32'd0);
        check("reset_bus", {20'd0, cdbid, cdbval}, 32'd0);
    endtask

    // Wait (bounded) for all expected broadcasts, then idle a few cycles so
    // any surplus broadcast is seen by the monitor.
    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, sb.size(), 32'd0);
        sb.delete();
        repeat (4) @(negedge clk);
    endtask

    // ------------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------------
    initial begin
        int run;
        rst = 1'b1;
        flush = 1'b0;
        clear_inputs();

        // 1: single result, latency and idle-zero afterwards
        do_reset();
        tick(); drive(3, 8'hA5, 4'h7); sb_push(8'hA5, 4'h7);
        @(negedge clk);
        tick(); clear_inputs();
        @(negedge clk);
        check("t1_transmit_at_t1", {31'd0, cdbtransmit}, (LAT == 1) ? 32'd1 : 32'd0);
        tick();
        @(negedge clk);
        check("t1_transmit_at_t2", {31'd0, cdbtransmit}, (LAT == 2) ? 32'd1 : 32'd0);
        tick();
        @(negedge clk);
        check("t1_idle_after", {31'd0, cdbtransmit}, 32'd0);
        check("t1_idle_bus", {20'd0, cdbid, cdbval}, 32'd0);
        drain("t1");

        // 2: FU0..2 together from rr_ptr=0 -> ids 1,2,3 back to back
        do_reset();
        tick(); drive(0, 8'h11, 4'h1); drive(1, 8'h22, 4'h2); drive(2, 8'h33, 4'h3);
        sb_push(8'h11, 4'h1); sb_push(8'h22, 4'h2); sb_push(8'h33, 4'h3);
        tick(); clear_inputs();
        tick(); @(negedge clk); check("t2_id_first", {28'd0, cdbid}, 32'd1);
        tick(); @(negedge clk); check("t2_id_second", {28'd0, cdbid}, 32'd2);
        tick(); @(negedge clk); check("t2_id_third", {28'd0, cdbid}, 32'd3);
        drain("t2");
        // rr_ptr is now 3: FU3 must beat FU2 when both arrive together
        tick(); drive(2, 8'h2A, 4'hA); drive(3, 8'h3B, 4'hB);
        sb_push(8'h3B, 4'hB); sb_push(8'h2A, 4'hA);
        tick(); clear_inputs();
        drain("t2_rr");

        // 3: FU5 fills while the CDB serves FU0..4; third result is dropped
        do_reset();
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(i, 8'(8'h10 + i), 4'(i));
            sb_push(8'(8'h10 + i), 4'(i));
        end
        drive(5, 8'hA1, 4'h5);
        tick(); clear_inputs(); drive(5, 8'hA2, 4'h5);
        sb_push(8'hA1, 4'h5); sb_push(8'hA2, 4'h5);
        @(negedge clk); check("t3_busy5_count1", {31'd0, fu_busy[5]}, 32'd0);
        tick(); clear_inputs(); drive(5, 8'hA3, 4'h5);   // refused
        @(negedge clk); check("t3_busy5_full", {31'd0, fu_busy[5]}, 32'd1);
        tick(); clear_inputs();
        @(negedge clk); check("t3_busy5_still_full", {31'd0, fu_busy[5]}, 32'd1);
        drain("t3");
        check("t3_busy_after", {24'd0, fu_busy}, 32'd0);

        // 4: every FU holds two results -> 0..7,0..7 with no idle cycle
        do_reset();
        tick();
        for (int i = 0; i < FU_COUNT; i++) begin
            drive(i, 8'(8'h40 + i), 4'(i));
            sb_push(8'(8'h40 + i), 4'(i));
        end
        tick(); clear_inputs();
        for (int i = 0; i < FU_COUNT; i++) begin
            drive(i, 8'(8'h80 + i), 4'(i));
            sb_push(8'(8'h80 + i), 4'(i));
        end
        tick(); clear_inputs();
        run = 0;
        for (int k = 0; k < 2 * FU_COUNT; k++) begin
            @(negedge clk);
            if (cdbtransmit) run++;
            tick();
        end
        check("t4_transmit_run", run, 32'd16);
        @(negedge clk); check("t4_idle_after", {31'd0, cdbtransmit}, 32'd0);
        drain("t4");

        // 5: flush with queues partly full
        do_reset();
        tick(); drive(1, 8'h51, 4'h1); drive(6, 8'h56, 4'h6);
        sb_push(8'h51, 4'h1);                 // FU1 goes out before the flush
        tick(); clear_inputs(); drive(6, 8'h66, 4'h6);
        tick(); clear_inputs(); flush = 1'b1;
        @(negedge clk); check("t5_busy6_before_flush", {31'd0, fu_busy[6]}, 32'd1);
        tick(); flush = 1'b0;
        @(negedge clk);
        check("t5_flush_transmit", {31'd0, cdbtransmit}, 32'd0);
        check("t5_flush_busy", {24'd0, fu_busy}, 32'd0);
        repeat (4) @(negedge clk);
        tick(); drive(2, 8'h5C, 4'hC); sb_push(8'h5C, 4'hC);
        tick(); clear_inputs();
        drain("t5");

        // 6: push refused on a full FU4 queue while its head is popped
        do_reset();
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(i, 8'(8'h20 + i), 4'(i));
            sb_push(8'(8'h20 + i), 4'(i));
        end
        drive(4, 8'hE1, 4'h4); sb_push(8'hE1, 4'h4);
        tick(); clear_inputs(); drive(4, 8'hE2, 4'h4); sb_push(8'hE2, 4'h4);
        for (int k = 0; k < 4; k++) begin     // held through the popping cycle
            tick(); clear_inputs(); drive(4, 8'hE3, 4'h4);
        end
        @(negedge clk); check("t6_busy4_full", {31'd0, fu_busy[4]}, 32'd1);
        tick(); clear_inputs();
        @(negedge clk); check("t6_busy4_after_pop", {31'd0, fu_busy[4]}, 32'd0);
        drain("t6");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
